pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The module SHALL have a single clock domain with a synchronous, active-high reset.
REQ-002 clock  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 next_pc  in  12  next-PC value from the PC adder (branch/jump/jr already resolved).
REQ-005 is_mult  in  1  current instruction is a multiply.
REQ-006 is_div  in  1  current instruction is a divide.
REQ-007 md_ready  in  1  multdiv result-ready strobe.
REQ-008 md_exception  in  1  multdiv exception flag, valid only with md_ready.
REQ-009 ext_stall  in  1  external (memory) stall request.
REQ-010 pc  out  12  registered program counter.
REQ-011 ctrl_mult  out  1  one-cycle multiply start pulse.
REQ-012 ctrl_div  out  1  one-cycle divide start pulse.
REQ-013 md_wb  out  1  one-cycle writeback enable for the multdiv result.
REQ-014 md_exc  out  1  one-cycle exception flag, concurrent with md_wb.
REQ-015 md_timeout  out  1  one-cycle pulse when a multdiv operation times out.
REQ-016 busy  out  1  high in any state other than RUN.

Function
REQ-017 States SHALL be RUN, START, WAIT and DONE, encoded in a registered FSM.
REQ-018 In RUN with ext_stall=1, pc SHALL hold and the state SHALL remain RUN.
REQ-019 In RUN with ext_stall=0 and is_mult=is_div=0, pc SHALL load next_pc at the clock edge.
REQ-020 In RUN with ext_stall=0 and is_mult or is_div high, pc SHALL hold, the operation type SHALL be latched, and the state SHALL go to START.
REQ-021 When is_mult and is_div are both high, the operation SHALL be treated as a multiply.
REQ-022 In START, exactly one of ctrl_mult or ctrl_div SHALL be high for that single cycle, per the latched type.
REQ-023 In START, the timeout counter SHALL clear, and the state SHALL go to WAIT unconditionally.
REQ-024 md_ready SHALL be ignored in START.
REQ-025 In WAIT, pc SHALL hold and the 6-bit timeout counter SHALL increment each cycle.
REQ-026 ext_stall SHALL be ignored in START and WAIT.
REQ-027 In WAIT, md_ready=1 SHALL move the state to DONE and register md_exception into an internal flag.
REQ-028 In WAIT, if the counter reaches 39 without md_ready, md_timeout SHALL pulse for one cycle.
REQ-029 On that timeout, pc SHALL load next_pc, the state SHALL return to RUN, and md_wb SHALL stay 0.
REQ-030 If md_ready arrives in the same cycle the counter reaches 39, md_ready SHALL win: go to DONE with no timeout pulse.
REQ-031 In DONE with ext_stall=0, md_wb SHALL be high, md_exc SHALL equal the registered flag, pc SHALL load next_pc, and the state SHALL return to RUN.
REQ-032 In DONE with ext_stall=1, the state SHALL remain DONE, pc SHALL hold, and md_wb/md_exc SHALL stay 0.
REQ-033 md_wb SHALL never be high for more than one cycle per operation.
REQ-034 Start pulses, md_wb, md_exc, md_timeout and busy SHALL be decoded from registered state only; no input-to-output combinational path is permitted.
REQ-035 pc SHALL load next_pc verbatim with no arithmetic; 12-bit wrap-around is the PC adder's responsibility.
REQ-036 A new multdiv operation SHALL NOT start until the state has returned to RUN.

Reset
REQ-037 While reset=1 at a clock edge: pc=12'h000, state=RUN, timeout counter=0, latched type and exception flag=0.
REQ-038 While reset=1, all pulse outputs and busy SHALL be 0 in the following cycle.
REQ-039 Reset SHALL take priority over every other input in every state, including mid-operation in START, WAIT or DONE.
REQ-040 After reset deasserts, the first pc update SHALL occur on the first edge with ext_stall=0.

Verification
REQ-041 Sequential run: reset, next_pc=pc+1, no stalls, 5 cycles -> pc=1,2,3,4,5; busy=0 throughout.
REQ-042 Multiply: at pc=12'h010, is_mult=1, next_pc=12'h011; md_ready 8 cycles after ctrl_mult -> ctrl_mult high exactly 1 cycle; pc=12'h010 until the DONE edge, then 12'h011; md_wb=1 for 1 cycle; md_exc=0.
REQ-043 Divide exception: is_div=1, md_ready=1 with md_exception=1 in WAIT, ext_stall=1 for 3 cycles in DONE -> md_wb and md_exc both pulse together only after ext_stall drops; pc holds during the stall.
REQ-044 Timeout: is_mult=1, md_ready never asserted -> md_timeout pulses on the 40th WAIT cycle, md_wb=0, pc=next_pc, state=RUN.
REQ-045 Priority and edge cases: is_mult=is_div=1 -> ctrl_mult only; md_ready in START is ignored; md_ready coincident with count 39 -> DONE, no md_timeout pulse.
REQ-046 Reset mid-WAIT at pc=12'h3FF -> next cycle pc=12'h000, busy=0, no md_wb pulse; pc=12'hFFF with next_pc=12'h000 -> pc=12'h000.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: advances the PC and stalls it while a multiply or divide is
// started, awaited (with a timeout) and written back.
module pc_sequencer (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic [11:0] i_next_pc,
   input  logic        i_is_mult,
   input  logic        i_is_div,
   input  logic        i_md_ready,
   input  logic        i_md_exception,
   input  logic        i_ext_stall,
   output logic [11:0] o_pc,
   output logic        o_ctrl_mult,
   output logic        o_ctrl_div,
   output logic        o_md_wb,
   output logic        o_md_exc,
   output logic        o_md_timeout,
   output logic        o_busy
);

   typedef enum logic [1:0] {StRun, StStart, StWait, StDone} state_e;

   localparam logic [5:0] TimeoutLast = 6'd39;

   state_e      r_state;
   logic [11:0] r_pc;
   logic [5:0]  r_cnt;
   logic        r_op_mult;
   logic        r_exc_flag;
   logic        r_md_wb;
   logic        r_md_exc;
   logic        r_md_timeout;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state      <= StRun;
         r_pc         <= 12'h000;
         r_cnt        <= 6'd0;
         r_op_mult    <= 1'b0;
         r_exc_flag   <= 1'b0;
         r_md_wb      <= 1'b0;
         r_md_exc     <= 1'b0;
         r_md_timeout <= 1'b0;
      end else begin
         r_md_wb      <= 1'b0;
         r_md_exc     <= 1'b0;
         r_md_timeout <= 1'b0;
         unique case (r_state)
            StRun: begin
               if (!i_ext_stall) begin
                  if (i_is_mult || i_is_div) begin
                     // Multiply wins when both are flagged.
                     r_op_mult <= i_is_mult;
                     r_state   <= StStart;
                  end else begin
                     r_pc <= i_next_pc;
                  end
               end
            end
            StStart: begin
               r_cnt   <= 6'd0;
               r_state <= StWait;
            end
            StWait: begin
               if (i_md_ready) begin
                  r_exc_flag <= i_md_exception;
                  r_state    <= StDone;
               end else if (r_cnt == TimeoutLast) begin
                  r_md_timeout <= 1'b1;
                  r_pc         <= i_next_pc;
                  r_state      <= StRun;
               end else begin
                  r_cnt <= r_cnt + 6'd1;
               end
            end
            StDone: begin
               if (!i_ext_stall) begin
                  r_md_wb  <= 1'b1;
                  r_md_exc <= r_exc_flag;
                  r_pc     <= i_next_pc;
                  r_state  <= StRun;
               end
            end
            default: r_state <= StRun;
         endcase
      end
   end

   // Pulses and busy come only from registers, never straight from inputs.
   assign o_pc         = r_pc;
   assign o_ctrl_mult  = (r_state == StStart) && r_op_mult;
   assign o_ctrl_div   = (r_state == StStart) && !r_op_mult;
   assign o_md_wb      = r_md_wb;
   assign o_md_exc     = r_md_exc;
   assign o_md_timeout = r_md_timeout;
   assign o_busy       = (r_state != StRun);

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a cycle model pushes expected outputs, which are
// popped and compared one edge later, plus directed checks on pulse timing.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [11:0] next_pc = 12'h000;
   logic        is_mult = 1'b0;
   logic        is_div = 1'b0;
   logic        md_ready = 1'b0;
   logic        md_exception = 1'b0;
   logic        ext_stall = 1'b0;
   logic [11:0] pc;
   logic        ctrl_mult, ctrl_div, md_wb, md_exc, md_timeout, busy;

   int n_checks = 0;
   int n_errors = 0;

   // Model state
   logic [11:0] m_pc = 12'h000;
   int          m_mode = 0;  // 0 run, 1 start, 2 wait, 3 done
   int          m_waited = 0;
   logic        m_mul = 1'b0;
   logic        m_exc = 1'b0;

   logic [17:0] exp_q[$];

   pc_sequencer u_dut (
      .i_clock       (clk),
      .i_reset       (rst),
      .i_next_pc     (next_pc),
      .i_is_mult     (is_mult),
      .i_is_div      (is_div),
      .i_md_ready    (md_ready),
      .i_md_exception(md_exception),
      .i_ext_stall   (ext_stall),
      .o_pc          (pc),
      .o_ctrl_mult   (ctrl_mult),
      .o_ctrl_div    (ctrl_div),
      .o_md_wb       (md_wb),
      .o_md_exc      (md_exc),
      .o_md_timeout  (md_timeout),
      .o_busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Drive one cycle, predict the post-edge outputs, then compare after the edge.
   task automatic step(input logic [11:0] npc, input logic mul, input logic div,
                       input logic rdy, input logic exc, input logic stall, input logic rs);
      logic wb, xo, to;
      logic [17:0] exp, obs;
      next_pc = npc; is_mult = mul; is_div = div;
      md_ready = rdy; md_exception = exc; ext_stall = stall; rst = rs;
      wb = 1'b0; xo = 1'b0; to = 1'b0;
      if (rs) begin
         m_pc = 12'h000; m_mode = 0; m_waited = 0; m_mul = 1'b0; m_exc = 1'b0;
      end else begin
         case (m_mode)
            0: if (!stall) begin
                  if (mul || div) begin m_mul = mul; m_mode = 1; end
                  else m_pc = npc;
               end
            1: begin m_mode = 2; m_waited = 0; end
            2: begin
                  m_waited++;
                  if (rdy) begin m_exc = exc; m_mode = 3; end
                  else if (m_waited == 40) begin to = 1'b1; m_pc = npc; m_mode = 0; end
               end
            default: if (!stall) begin
                  wb = 1'b1; xo = m_exc; m_pc = npc; m_mode = 0;
               end
         endcase
      end
      exp = {m_pc, (m_mode == 1) && m_mul, (m_mode == 1) && !m_mul, wb, xo, to, m_mode != 0};
      exp_q.push_back(exp);
      @(posedge clk);
      #1;
      obs = {pc, ctrl_mult, ctrl_div, md_wb, md_exc, md_timeout, busy};
      check("cycle", {14'd0, obs}, {14'd0, exp_q.pop_front()});
   endtask

   initial begin
      int n_cm, n_cd, n_wb, wb_at, exc_at, to_at, n_to;
      #1;
      step(12'h123, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(12'h456, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      check("reset_pc", {20'd0, pc}, 32'h000);
      check("reset_busy", {31'd0, busy}, 32'd0);

      // First edge after reset stalled: pc holds.
      step(12'h777, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("post_reset_stall", {20'd0, pc}, 32'h000);

      // Sequential run
      for (int i = 0; i < 5; i++) begin
         step(pc + 12'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         check("seq_busy", {31'd0, busy}, 32'd0);
      end
      check("seq_pc", {20'd0, pc}, 32'h005);

      // Multiply at 0x010, ready 8 cycles after ctrl_mult
      step(12'h010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(12'h011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      n_cm = ctrl_mult ? 1 : 0; n_wb = 0;
      for (int i = 1; i <= 12; i++) begin
         if (i <= 9) check("mul_pc_hold", {20'd0, pc}, 32'h010);
         step(12'h011, 1'b0, 1'b0, i == 9, 1'b0, 1'b0, 1'b0);
         if (ctrl_mult) n_cm++;
         if (md_wb) n_wb++;
      end
      check("mul_ctrl_cnt", n_cm, 1);
      check("mul_wb_cnt", n_wb, 1);
      check("mul_pc", {20'd0, pc}, 32'h011);

      // Divide with exception and stall held in DONE
      step(12'h020, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("div_ctrl", {30'd0, ctrl_mult, ctrl_div}, 32'd1);
      wb_at = -1; exc_at = -1;
      for (int i = 0; i <= 8; i++) begin
         step(12'h021, 1'b0, 1'b0, i == 2, 1'b1, (i == 1) || (i >= 3 && i <= 5), 1'b0);
         if (md_wb && wb_at < 0) wb_at = i;
         if (md_exc && exc_at < 0) exc_at = i;
      end
      check("div_wb_at", wb_at, 6);
      check("div_exc_at", exc_at, 6);

      // Timeout: md_ready never arrives
      step(12'h030, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      to_at = -1; n_wb = 0; n_to = 0;
      for (int i = 0; i <= 44; i++) begin
         step(12'h031, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         if (md_timeout) begin n_to++; if (to_at < 0) to_at = i; end
         if (md_wb) n_wb++;
      end
      check("to_at", to_at, 40);
      check("to_cnt", n_to, 1);
      check("to_wb", n_wb, 0);
      check("to_pc", {20'd0, pc}, 32'h031);

      // Both flags -> multiply; ready in START ignored; ready at count 39 wins
      step(12'h040, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("both_ctrl", {30'd0, ctrl_mult, ctrl_div}, 32'd2);
      n_to = 0; wb_at = -1;
      for (int i = 0; i <= 43; i++) begin
         step(12'h041, 1'b0, 1'b0, (i == 0) || (i == 40), 1'b0, 1'b0, 1'b0);
         if (i == 0) check("start_rdy_ignored", {31'd0, busy}, 32'd1);
         if (md_timeout) n_to++;
         if (md_wb && wb_at < 0) wb_at = i;
      end
      check("race_no_to", n_to, 0);
      check("race_wb_at", wb_at, 41);

      // Reset mid-WAIT at 0x3FF, then 0xFFF -> 0x000 wrap
      step(12'h3FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(12'h400, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(12'h400, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("pre_rst_pc", {20'd0, pc}, 32'h3FF);
      step(12'h400, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      check("rst_wait", {19'd0, pc, busy}, 32'd0);
      check("rst_wb", {31'd0, md_wb}, 32'd0);
      step(12'hFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("wrap_pc", {20'd0, pc}, 32'h000);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
